// File: rtl/audio_pkg.sv
// Shared types and default dimensions for the audio front end feeding the FFT processor.
package audio_pkg;
  localparam int SAMPLE_W          = 16;
  localparam int SAMPLES           = 2048;
  localparam int INPUT_SIZE        = 512;
  localparam int SAMPLES_PER_INPUT = INPUT_SIZE / SAMPLE_W;
  localparam int INPUTS_TO_FILL    = SAMPLES / SAMPLES_PER_INPUT;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    PAD      = 2'd1,
    WAIT_ACK = 2'd2
  } packer_state_t;
endpackage

// File: rtl/audio_frame_packer.sv
// Packs PCM samples into wide words and writes one frame of indexed words into the
// FFT input buffer, zero-padding short frames and holding until the frame is acknowledged.
module audio_frame_packer
  import audio_pkg::*;
#(
  parameter int INPUT_SIZE = audio_pkg::INPUT_SIZE,
  parameter int SAMPLES    = audio_pkg::SAMPLES,
  parameter int SAMPLE_W   = audio_pkg::SAMPLE_W,
  localparam int SPI       = INPUT_SIZE / SAMPLE_W,
  localparam int ITF       = SAMPLES / SPI,
  localparam int SLOT_W    = $clog2(SPI),
  localparam int WORD_W    = $clog2(ITF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [SAMPLE_W-1:0]   s_sample,
  input  logic                  s_last,
  output logic                  data_wr_en,
  output logic [WORD_W-1:0]     input_index,
  output logic [INPUT_SIZE-1:0] data_in,
  output logic                  frame_done,
  input  logic                  frame_ack
);

  if (((INPUT_SIZE % SAMPLE_W) != 0) || ((SAMPLES % SPI) != 0)) begin : g_bad_params
    $error("audio_frame_packer: INPUT_SIZE/SAMPLE_W/SAMPLES must divide evenly");
  end

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SPI - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(ITF - 1);

  packer_state_t         state_q, state_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [INPUT_SIZE-1:0] asm_q, asm_d;
  logic                  wr_en_q, wr_en_d;
  logic [WORD_W-1:0]     index_q, index_d;
  logic [INPUT_SIZE-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic [INPUT_SIZE-1:0] asm_tmp;
  logic                  xfer;

  assign s_ready     = (state_q == FILL) && !rst;
  assign xfer        = s_valid && s_ready;
  assign data_wr_en  = wr_en_q;
  assign input_index = index_q;
  assign data_in     = data_q;
  assign frame_done  = done_q;

  // Next-state logic: slot assembly, word emission, padding and frame handshake.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    word_d  = word_q;
    asm_d   = asm_q;
    wr_en_d = 1'b0;
    index_d = index_q;
    data_d  = data_q;
    done_d  = 1'b0;
    asm_tmp = asm_q;
    asm_tmp[32'(slot_q) * SAMPLE_W +: SAMPLE_W] = s_sample;
    case (state_q)
      FILL: begin
        if (xfer) begin
          if ((slot_q == SLOT_LAST) || s_last) begin
            // The sample in flight is merged so the word leaves with no bubble.
            wr_en_d = 1'b1;
            index_d = word_q;
            data_d  = asm_tmp;
            asm_d   = '0;
            slot_d  = '0;
            if (word_q == WORD_LAST) begin
              word_d  = '0;
              state_d = WAIT_ACK;
            end else begin
              word_d  = word_q + WORD_W'(1);
              state_d = s_last ? PAD : FILL;
            end
          end else begin
            asm_d  = asm_tmp;
            slot_d = slot_q + SLOT_W'(1);
          end
        end else begin
          state_d = FILL;
        end
      end
      PAD: begin
        wr_en_d = 1'b1;
        index_d = word_q;
        data_d  = '0;
        if (word_q == WORD_LAST) begin
          word_d  = '0;
          state_d = WAIT_ACK;
        end else begin
          word_d = word_q + WORD_W'(1);
        end
      end
      WAIT_ACK: begin
        // frame_done lags entry by a cycle so it never overlaps the final write.
        if (frame_ack) begin
          state_d = FILL;
          word_d  = '0;
          slot_d  = '0;
          done_d  = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = FILL;
        slot_d  = '0;
        word_d  = '0;
        asm_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      slot_q  <= '0;
      word_q  <= '0;
      asm_q   <= '0;
      wr_en_q <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      word_q  <= word_d;
      asm_q   <= asm_d;
      wr_en_q <= wr_en_d;
      index_q <= index_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_audio_frame_packer.sv
// Scoreboard bench for audio_frame_packer: expected writes are queued by the stimulus
// and a negedge monitor compares every data_wr_en against the queue head.
module tb_audio_frame_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [15:0]  s_sample;
  logic         s_last;
  logic         data_wr_en;
  logic [5:0]   input_index;
  logic [511:0] data_in;
  logic         frame_done;
  logic         frame_ack;

  typedef struct {
    logic [5:0]   idx;
    logic [511:0] data;
    int           gap;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_wr_cyc = 0;

  audio_frame_packer dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sample(s_sample),
    .s_last(s_last), .data_wr_en(data_wr_en), .input_index(input_index), .data_in(data_in),
    .frame_done(frame_done), .frame_ack(frame_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] make_word(input int base, input int nvalid);
    logic [511:0] w;
    w = '0;
    for (int k = 0; k < 32; k++)
      if (k < nvalid) w[k*16 +: 16] = 16'(base + k);
    return w;
  endfunction

  // Full frame with sample n = off + n; gap_chk enables the 32-cycle cadence check.
  task automatic push_frame(input int off, input bit gap_chk);
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      e.idx  = 6'(i);
      e.data = make_word(off + 32 * i, 32);
      e.gap  = (gap_chk && i > 0) ? 32 : 0;
      q.push_back(e);
    end
  endtask

  task automatic send(input logic [15:0] v, input bit last, input int gap);
    int g;
    repeat (gap) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b1; s_sample = v; s_last = last;
    g = 0;
    while (!s_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("send_timeout", 512'(s_ready), 512'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (!frame_done && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("frame_done_wait", 512'(frame_done), 512'd1);
  endtask

  task automatic ack();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    chk("ack_done_low", 512'(frame_done), 512'd0);
    chk("ack_ready", 512'(s_ready), 512'd1);
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && data_wr_en) begin
      if (q.size() == 0) begin
        chk("unexpected_write", 512'(input_index), 512'h3ff);
      end else begin
        e = q.pop_front();
        chk("input_index", 512'(input_index), 512'(e.idx));
        chk("data_in", data_in, e.data);
        if (e.gap != 0) chk("write_gap", 512'(cyc - last_wr_cyc), 512'(e.gap));
      end
      last_wr_cyc = cyc;
    end
  end

  initial begin
    exp_t e;
    rst = 1'b1; s_valid = 1'b1; s_sample = 16'd0; s_last = 1'b0; frame_ack = 1'b0;

    // 1: reset holds off transfers even with s_valid asserted
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 512'(s_ready), 512'd0);
      chk("rst_wr_en", 512'(data_wr_en), 512'd0);
      chk("rst_done", 512'(frame_done), 512'd0);
    end
    chk("rst_index", 512'(input_index), 512'd0);
    chk("rst_data", data_in, 512'd0);
    rst = 1'b0; s_valid = 1'b0;
    #1 chk("ready_after_rst", 512'(s_ready), 512'd1);

    // 2: full back-to-back frame
    push_frame(0, 1'b1);
    for (int n = 0; n < 2048; n++) send(16'(n), 1'b0, 0);
    idle();
    chk("last_wr_en", 512'(data_wr_en), 512'd1);
    chk("last_done_low", 512'(frame_done), 512'd0);
    chk("last_index", 512'(input_index), 512'd63);
    @(negedge clk);
    chk("done_after_last", 512'(frame_done), 512'd1);
    chk("wait_ready", 512'(s_ready), 512'd0);

    // 3: s_valid held in WAIT_ACK must not transfer; index/data hold
    s_valid = 1'b1; s_sample = 16'hbeef;
    repeat (10) begin
      @(negedge clk);
      chk("wait_ready_hold", 512'(s_ready), 512'd0);
      chk("wait_done_hold", 512'(frame_done), 512'd1);
    end
    chk("hold_index", 512'(input_index), 512'd63);
    s_valid = 1'b0;
    ack();

    // 4: short frame of 40 samples, zero padded
    e.idx = 6'd0; e.data = make_word(0, 32); e.gap = 0; q.push_back(e);
    e.idx = 6'd1; e.data = make_word(32, 8); e.gap = 0; q.push_back(e);
    for (int i = 2; i < 64; i++) begin
      e.idx = 6'(i); e.data = '0; e.gap = 1; q.push_back(e);
    end
    for (int n = 0; n < 40; n++) send(16'(n), n == 39, 0);
    idle();
    wait_done();
    chk("short_queue_empty", 512'(q.size()), 512'd0);
    ack();

    // 5: irregular valid gaps give the same word sequence
    push_frame(0, 1'b0);
    for (int n = 0; n < 2048; n++) send(16'(n), 1'b0, int'($urandom_range(0, 1)));
    idle();
    wait_done();
    chk("irregular_queue_empty", 512'(q.size()), 512'd0);
    ack();

    // 6: reset mid-frame discards the partial word, then a fresh frame from index 0
    for (int i = 0; i < 3; i++) begin
      e.idx = 6'(i); e.data = make_word(32 * i, 32); e.gap = 0; q.push_back(e);
    end
    for (int n = 0; n < 100; n++) send(16'(n), 1'b0, 0);
    @(negedge clk);
    s_valid = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_done", 512'(frame_done), 512'd0);
    chk("mid_rst_queue", 512'(q.size()), 512'd0);
    repeat (40) @(negedge clk);
    push_frame(16'h1000, 1'b1);
    for (int n = 0; n < 2048; n++) send(16'(16'h1000 + n), 1'b0, 0);
    idle();
    wait_done();
    ack();

    repeat (5) @(negedge clk);
    chk("final_queue_empty", 512'(q.size()), 512'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
